// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - uop, instruction format and encoder error types
// Shared by instr_encoder and EncFifo.
package instr_encoder_pkg;

  typedef logic [4:0] reg_t;
  typedef logic [2:0] funct3_t;

  typedef enum logic [1:0] {EX_NONE, EX_ILLEGAL, EX_FAULT, EX_BREAK} ex_t;
  typedef enum logic [1:0] {FU_NONE, FU_INTALU, FU_MUL, FU_BRANCH} fu_t;

  // Encoding of intalu_t is the ALU funct3 value.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_AND  = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_SHRA = 3'd7
  } intalu_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSVD} mem_size_t;

  typedef struct packed {
    intalu_t intalu;
  } uop_op_t;

  typedef struct packed {
    logic      en;
    logic      isSt;
    mem_size_t size;
    logic      signExtend;
  } mem_op_t;

  typedef struct packed {
    ex_t         ex;
    fu_t         fu;
    uop_op_t     op;
    reg_t        rd;
    reg_t        rs1;
    reg_t        rs2;
    logic [31:0] imm;
    logic        immValid;
    mem_op_t     memOp;
  } dec_t;

  typedef enum logic [2:0] {
    ENC_ERR_NONE  = 3'd0,
    ENC_ERR_EX    = 3'd1,
    ENC_ERR_FU    = 3'd2,
    ENC_ERR_IMM   = 3'd3,
    ENC_ERR_FIELD = 3'd4
  } encErr_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_NOP    = 7'h0f,
    OP_ARITHI = 7'h13,
    OP_STORE  = 7'h23,
    OP_ARITH  = 7'h33
  } opcode_t;

  localparam funct3_t LD_B  = 3'd0;
  localparam funct3_t LD_H  = 3'd1;
  localparam funct3_t LD_W  = 3'd2;
  localparam funct3_t LD_BS = 3'd4;
  localparam funct3_t LD_HS = 3'd5;
  localparam funct3_t ST_B  = 3'd0;
  localparam funct3_t ST_H  = 3'd1;
  localparam funct3_t ST_W  = 3'd2;

  typedef struct packed {
    logic [6:0] funct7;
    reg_t       rs2;
    reg_t       rs1;
    funct3_t    funct3;
    reg_t       rd;
    opcode_t    op;
  } r_t;

  typedef struct packed {
    logic [11:0] imm;
    reg_t        rs1;
    funct3_t     funct3;
    reg_t        rd;
    opcode_t     op;
  } i_t;

  typedef struct packed {
    logic [6:0] imm7;
    reg_t       rs2;
    reg_t       rs1;
    funct3_t    funct3;
    logic [4:0] imm5;
    opcode_t    op;
  } s_t;

  typedef union packed {
    r_t          r;
    i_t          i;
    s_t          s;
    logic [31:0] raw;
  } enc_t;

  typedef struct packed {
    enc_t    enc;
    encErr_t err;
  } q_entry_t;

  // True when imm is a sign-extended 12-bit value.
  function automatic logic imm12_ok(input logic [31:0] imm);
    return (&imm[31:11]) || !(|imm[31:11]);
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// rtl/instr_encoder_fifo.sv - EncFifo: DEPTH-entry valid/ready queue, generic payload
// Head is read straight from storage, so the output is register-sourced.
module EncFifo #(
  parameter int  DEPTH     = 2,
  parameter type payload_t = logic [7:0]
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     inValid,
  output logic     inReady,
  input  payload_t inData,
  output logic     outValid,
  input  logic     outReady,
  output payload_t outData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  payload_t        mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign inReady  = (count != CW'(DEPTH));
  assign outValid = (count != '0);
  assign outData  = mem[rptr];
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  // Storage is cleared on reset so the head reads as all-zero until first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= inData;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes dec_t uops into 32-bit words through an output queue
// Optional reject counter: define INSTR_ENCODER_ERRCNT_EN to add the errCnt port.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    inValid,
  output logic    inReady,
  input  dec_t    inUop,
  output logic    outValid,
  input  logic    outReady,
  output enc_t    outEnc,
  output encErr_t outErr
`ifdef INSTR_ENCODER_ERRCNT_EN
  ,
  output logic [15:0] errCnt
`endif
);

  enc_t     enc;
  encErr_t  err;
  funct3_t  ld_f3;
  funct3_t  st_f3;
  q_entry_t in_entry;
  q_entry_t head;

  always_comb begin
    ld_f3 = LD_W;
    case (inUop.memOp.size)
      SZ_B:    ld_f3 = inUop.memOp.signExtend ? LD_BS : LD_B;
      SZ_H:    ld_f3 = inUop.memOp.signExtend ? LD_HS : LD_H;
      default: ld_f3 = LD_W;
    endcase
    st_f3 = ST_W;
    case (inUop.memOp.size)
      SZ_B:    st_f3 = ST_B;
      SZ_H:    st_f3 = ST_H;
      default: st_f3 = ST_W;
    endcase
  end

  // Rules are checked in priority order; enc only leaves zero on success.
  always_comb begin
    enc = '0;
    err = ENC_ERR_NONE;
    if (inUop.ex != EX_NONE) begin
      err = ENC_ERR_EX;
    end else if (inUop.fu == FU_NONE && !inUop.memOp.en) begin
      enc.r.op = OP_NOP;
    end else if (inUop.fu != FU_INTALU) begin
      err = ENC_ERR_FU;
    end else if (!inUop.memOp.en) begin
      if (inUop.immValid) begin
        if (!imm12_ok(inUop.imm)) begin
          err = ENC_ERR_IMM;
        end else if (inUop.rs2 != '0) begin
          err = ENC_ERR_FIELD;
        end else begin
          enc.i.op     = OP_ARITHI;
          enc.i.imm    = inUop.imm[11:0];
          enc.i.rs1    = inUop.rs1;
          enc.i.rd     = inUop.rd;
          enc.i.funct3 = inUop.op.intalu;
        end
      end else begin
        enc.r.op     = OP_ARITH;
        enc.r.rs2    = inUop.rs2;
        enc.r.rs1    = inUop.rs1;
        enc.r.rd     = inUop.rd;
        enc.r.funct3 = inUop.op.intalu;
      end
    end else if (!inUop.memOp.isSt) begin
      if (inUop.op.intalu != ALU_ADD || !inUop.immValid || inUop.rs2 != '0 ||
          inUop.memOp.size == SZ_RSVD ||
          (inUop.memOp.size == SZ_W && inUop.memOp.signExtend)) begin
        err = ENC_ERR_FIELD;
      end else if (!imm12_ok(inUop.imm)) begin
        err = ENC_ERR_IMM;
      end else begin
        enc.i.op     = OP_LOAD;
        enc.i.imm    = inUop.imm[11:0];
        enc.i.rs1    = inUop.rs1;
        enc.i.rd     = inUop.rd;
        enc.i.funct3 = ld_f3;
      end
    end else begin
      if (inUop.op.intalu != ALU_ADD || !inUop.immValid || inUop.rd != '0 ||
          inUop.memOp.signExtend || inUop.memOp.size == SZ_RSVD) begin
        err = ENC_ERR_FIELD;
      end else if (!imm12_ok(inUop.imm)) begin
        err = ENC_ERR_IMM;
      end else begin
        enc.s.op     = OP_STORE;
        enc.s.imm7   = inUop.imm[11:5];
        enc.s.imm5   = inUop.imm[4:0];
        enc.s.rs1    = inUop.rs1;
        enc.s.rs2    = inUop.rs2;
        enc.s.funct3 = st_f3;
      end
    end
  end

  assign in_entry.enc = enc;
  assign in_entry.err = err;

  EncFifo #(
    .DEPTH     (DEPTH),
    .payload_t (q_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (in_entry),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (head)
  );

  assign outEnc = head.enc;
  assign outErr = head.err;

`ifdef INSTR_ENCODER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCnt <= '0;
    end else if (inValid && inReady && err != ENC_ERR_NONE && errCnt != 16'hffff) begin
      errCnt <= errCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with directed vectors
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    inValid = 1'b0;
  logic    outReady = 1'b0;
  dec_t    inUop = '0;
  logic    inReady;
  logic    outValid;
  enc_t    outEnc;
  encErr_t outErr;
`ifdef INSTR_ENCODER_ERRCNT_EN
  logic [15:0] errCnt;
`endif

  int       total = 0;
  int       bad = 0;
  int       nerr = 0;
  q_entry_t exp_q[$];

  instr_encoder #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .inUop    (inUop),
    .outValid (outValid),
    .outReady (outReady),
    .outEnc   (outEnc),
    .outErr   (outErr)
`ifdef INSTR_ENCODER_ERRCNT_EN
    ,
    .errCnt   (errCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic dec_t mk(input fu_t fu, input intalu_t alu, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic iv, input logic en,
                              input logic st, input mem_size_t sz, input logic sx);
    dec_t u;
    u.ex                = EX_NONE;
    u.fu                = fu;
    u.op.intalu         = alu;
    u.rd                = rd;
    u.rs1               = rs1;
    u.rs2               = rs2;
    u.imm               = imm;
    u.immValid          = iv;
    u.memOp.en          = en;
    u.memOp.isSt        = st;
    u.memOp.size        = sz;
    u.memOp.signExtend  = sx;
    return u;
  endfunction

  task automatic push(input dec_t u, input logic [31:0] w, input encErr_t er);
    q_entry_t e;
    int       n;
    logic     ok;
    e.enc.raw = w;
    e.err     = er;
    inUop     = u;
    inValid   = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      if (er != ENC_ERR_NONE) nerr++;
    end
    #1 inValid = 1'b0;
  endtask

  // Monitor: every output handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", outEnc, 32'hdeadbeef);
      end else begin
        q_entry_t e;
        e = exp_q.pop_front();
        chk("out_enc", outEnc, e.enc);
        chk("out_err", 32'(outErr), 32'(e.err));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    dec_t u;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_out_enc", outEnc, 32'd0);
    chk("rst_out_err", 32'(outErr), 32'(ENC_ERR_NONE));
    chk("rst_in_ready", 32'(inReady), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency and stability on an empty queue.
    chk("pre_out_valid", 32'(outValid), 32'd0);
    push(mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h002081b3, ENC_ERR_NONE);
    chk("lat_out_valid", 32'(outValid), 32'd1);
    @(posedge clk);
    #1;
    chk("hold_out_enc", outEnc, 32'h002081b3);
    chk("hold_out_valid", 32'(outValid), 32'd1);
    outReady = 1'b1;

    push(mk(FU_INTALU, ALU_ADD, 5'd5, 5'd6, 5'd0, 32'hfffff800, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h80030293, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_ADD, 5'd5, 5'd6, 5'd0, 32'h00000800, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0, ENC_ERR_IMM);
    push(mk(FU_INTALU, ALU_ADD, 5'd0, 5'd2, 5'd7, 32'hffffffe5, 1'b1, 1'b1, 1'b1, SZ_W, 1'b0),
         32'hfe7122a3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_ADD, 5'd4, 5'd8, 5'd0, 32'h10, 1'b1, 1'b1, 1'b0, SZ_W, 1'b1),
         32'h0, ENC_ERR_FIELD);
    push(mk(FU_INTALU, ALU_ADD, 5'd4, 5'd8, 5'd0, 32'h10, 1'b1, 1'b1, 1'b0, SZ_H, 1'b1),
         32'h01045203, ENC_ERR_NONE);
    push(mk(FU_NONE, ALU_SUB, 5'd9, 5'd1, 5'd2, 32'h5, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0000000f, ENC_ERR_NONE);
    u = mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0);
    u.ex = EX_FAULT;
    push(u, 32'h0, ENC_ERR_EX);
    push(mk(FU_MUL, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0, ENC_ERR_FU);
    push(mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd3, 32'h4, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0, ENC_ERR_FIELD);
    push(mk(FU_INTALU, ALU_ADD, 5'd1, 5'd2, 5'd7, 32'h4, 1'b1, 1'b1, 1'b1, SZ_W, 1'b0),
         32'h0, ENC_ERR_FIELD);
    push(mk(FU_INTALU, ALU_SHRA, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h01ffffb3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_SUB, 5'd4, 5'd8, 5'd0, 32'h10, 1'b1, 1'b1, 1'b0, SZ_H, 1'b0),
         32'h0, ENC_ERR_FIELD);
    push(mk(FU_INTALU, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'hffffffff, 1'b1, 1'b1, 1'b0, SZ_B, 1'b0),
         32'hfff10083, ENC_ERR_NONE);
    drain();

    // Backpressure: fill to DEPTH, third offer stalls until a pop frees a slot.
    outReady = 1'b0;
    push(mk(FU_INTALU, ALU_XOR, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h003140b3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_OR, 5'd2, 5'd3, 5'd0, 32'h7ff, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h7ff1a113, ENC_ERR_NONE);
    fork
      push(mk(FU_INTALU, ALU_ADD, 5'd0, 5'd4, 5'd5, 32'h3f, 1'b1, 1'b1, 1'b1, SZ_B, 1'b0),
           32'h02520fa3, ENC_ERR_NONE);
      begin
        @(negedge clk);
        chk("full_in_ready_0", 32'(inReady), 32'd0);
        chk("full_hold_enc_0", outEnc, 32'h003140b3);
        @(negedge clk);
        chk("full_in_ready_1", 32'(inReady), 32'd0);
        chk("full_hold_enc_1", outEnc, 32'h003140b3);
        @(posedge clk);
        #1 outReady = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ready", 32'(inReady), 32'd0);
        @(negedge clk);
        chk("after_pop_ready", 32'(inReady), 32'd1);
      end
    join
    drain();

    // Streaming with push and pop every cycle.
    push(mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h002081b3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_SHRA, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h01ffffb3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_ADD, 5'd5, 5'd6, 5'd0, 32'hfffff800, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h80030293, ENC_ERR_NONE);
    push(mk(FU_NONE, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0000000f, ENC_ERR_NONE);
    drain();

    // Reset mid-operation discards queued entries at once.
    outReady = 1'b0;
    push(mk(FU_INTALU, ALU_XOR, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h003140b3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_OR, 5'd2, 5'd3, 5'd0, 32'h7ff, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h7ff1a113, ENC_ERR_NONE);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", 32'(outValid), 32'd0);
    chk("midrst_in_ready", 32'(inReady), 32'd1);
    chk("midrst_out_enc", outEnc, 32'd0);
    exp_q.delete();
    nerr = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    outReady = 1'b1;
    push(mk(FU_INTALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h002081b3, ENC_ERR_NONE);
    push(mk(FU_INTALU, ALU_ADD, 5'd5, 5'd6, 5'd0, 32'h00000800, 1'b1, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0, ENC_ERR_IMM);
    push(mk(FU_MUL, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, SZ_B, 1'b0),
         32'h0, ENC_ERR_FU);
    drain();
`ifdef INSTR_ENCODER_ERRCNT_EN
    chk("err_cnt", 32'(errCnt), 32'(nerr));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Converts decoded micro-ops (`Uop::dec_t`) back into 32-bit instruction words (`Instr::enc_t`).
- Inverse of the instruction decoder. A legal uop that is encoded and then decoded again yields the same `dec_t`.
- Used by the self-test sequencer and the trace replayer to build instruction streams.
- Valid/ready on both sides, with a registered output queue.

## Interface
Parameters:
- DEPTH, 2, output queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inValid  in  1  uop offered.
- inReady  out  1  uop accepted this cycle when inValid&&inReady.
- inUop  in  Uop::dec_t  uop to encode.
- outValid  out  1  queue head valid.
- outReady  in  1  consumer takes head when outValid&&outReady.
- outEnc  out  Instr::enc_t  encoded word.
- outErr  out  Uop::encErr_t  ENC_ERR_NONE or reason uop is unencodable.
- errCnt  out  16  saturating reject counter (only with macro, see Configuration).

## Operation
Combinational encode of inUop, first matching rule wins:
- **Pre-existing exception.** `ex != EX_NONE` → ENC_ERR_EX.
- **NOP.** `fu == FU_NONE` and `!memOp.en` → `op = OP_NOP`, all other fields 0.
- **Non-ALU uop.** Any other `fu != FU_INTALU` → ENC_ERR_FU.
- **Arithmetic** (`!memOp.en`):
  - funct3 comes from `op.intalu`: ADD, SUB, OR, AND, XOR, SHL, SHR, SHRA.
  - If immValid → OP_ARITHI, with `i.imm = imm[11:0]`, rd, rs1.
  - Otherwise → OP_ARITH, with rd, rs1, rs2.
  - ARITHI requires `imm[31:11]` all equal (sign-extended 12-bit), else ENC_ERR_IMM.
  - ARITHI requires `rs2 == 0`, else ENC_ERR_FIELD.
- **Load** (`memOp.en && !isSt`):
  - Requires `intalu == ADD`, immValid, `rs2 == 0`, and `!isSt`-only fields legal, else ENC_ERR_FIELD.
  - funct3: B→LD_B / LD_BS and H→LD_H / LD_HS, chosen by signExtend; W→LD_W.
  - W with signExtend → ENC_ERR_FIELD.
  - Immediate range rule as for ARITHI.
- **Store** (`memOp.en && isSt`):
  - Requires ADD, immValid, `rd == 0`, `!signExtend`, else ENC_ERR_FIELD.
  - Fields: `s.imm7 = imm[11:5]`, `s.imm5 = imm[4:0]`, rs1, rs2.
  - funct3: ST_B / ST_H / ST_W.
- **Rejected uops.** On any error, outEnc is all-zero. The entry is still queued, so output order matches input order.
- **Queue.**
  - DEPTH-entry FIFO holding {enc, err}.
  - `inReady = (count != DEPTH)`; this does not depend on outReady.
  - Push and pop in the same cycle keep count unchanged, including at full.
  - Pointers wrap modulo DEPTH.

## Timing
- **Reset.** count=0, pointers=0, outValid=0, outEnc=0, outErr=ENC_ERR_NONE, errCnt=0.
- **Latency.** Accept at edge N; outValid is high after edge N (visible in cycle N+1) when the queue was empty. There is no combinational in→out path.
- **Stability.** outEnc/outErr are driven from the head register. They stay stable while outValid&&!outReady.
- **Full.** inReady=0 in the cycle count==DEPTH. It rises the cycle after a pop.
- **Empty.** outValid=0; outReady is ignored.
- **Reset mid-operation.** Queued entries are discarded immediately, regardless of handshakes in flight.

## Configuration
- **INSTR_ENCODER_ERRCNT_EN defined:**
  - Adds the errCnt port.
  - Increments by 1 on each accepted uop whose err != ENC_ERR_NONE.
  - Saturates at 16'hFFFF.
- **Not defined:** no port and no counter logic. Encoding and queue behaviour are identical in both builds.

## Structure
- **Uop package additions:**
  - `encErr_t` enum: ENC_ERR_NONE, ENC_ERR_EX, ENC_ERR_FU, ENC_ERR_IMM, ENC_ERR_FIELD.
- **Instr package additions:** none. Existing opcode, funct3 and format typedefs are reused.
- **Sub-modules:**
  - `EncFifo`, parameterized by DEPTH and a payload type; holds the queue and handshake logic.
  - Encode rules are an always_comb block in the top module.

## Test plan
- **ARITH.** Push {INTALU, ADD, rd=3, rs1=1, rs2=2, immValid=0} → next cycle outValid=1, OP_ARITH, funct3=ADD, rd=3, rs1=1, rs2=2, err NONE.
- **ARITHI with negative immediate.** imm=32'hFFFFF800 → i.imm=12'h800, err NONE.
- **ARITHI out of range.** imm=32'h00000800 → ENC_ERR_IMM, outEnc=0.
- **Store split.** ST_W with imm=32'hFFFFFFE5 → imm7=7'h7F, imm5=5'h05.
- **Load size/sign.** LD_W with signExtend=1 → ENC_ERR_FIELD.
- **Backpressure.**
  - Hold outReady=0 and push 3 uops: inReady drops after 2, with DEPTH=2.
  - Release outReady: words emerge in order, one per cycle.
  - Simultaneous push/pop at full keeps count at 2.
- **Round trip.** Random legal uops fed through instr_encoder then the decoder reproduce the input uop. With the macro, 5 illegal uops give errCnt=5.
